// File: rtl/vga_capture.sv
// vga_capture: receive end of the VGA pixel interface.
//
// Samples a VGA stream (normally looped back from vga_counters) on the rising edge of
// VGA_CLK as seen in the clk domain. Each active pixel is thresholded to 1 bpp
// (R+G+B >= THRESH). Pixels are packed 32 per word, and each word is written to a 1-bpp
// framebuffer through an Avalon-MM master at address y*(H_ACTIVE/32) + x/32.
// A start pulse captures exactly one frame.
//
// Optional feature: define CAPTURE_CHECKSUM_EN to add the frame_sum output. It is a
// rotate-xor checksum of every accepted write since the last start.
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   start          pulse: arm capture of the next frame (honoured in IDLE/DONE only)
//   abort          pulse: return to IDLE from any state
//   VGA_CLK        pixel clock level, sampled in the clk domain
//   VGA_HS         hsync, active low (monitored only)
//   VGA_VS         vsync, active low; its rising edge starts a frame
//   VGA_BLANK_n    1 = active video
//   VGA_R/G/B      8-bit colour components
//   av_address     framebuffer word address
//   av_writedata   packed pixels, bit i = pixel with x%32 == i
//   av_write       write request
//   av_waitrequest slave stall
//   busy           capture armed or in progress
//   done           sticky: frame complete, cleared by start
//   overflow       sticky: a word was dropped while a write was pending, cleared by start
//   line_err       sticky: a line had the wrong active length, cleared by start
//   frame_sum      (CAPTURE_CHECKSUM_EN only) rotate-xor checksum of accepted writes
module vga_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter logic [9:0]  THRESH   = 10'd384
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        VGA_CLK,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_BLANK_n,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  output logic [14:0] av_address,
  output logic [31:0] av_writedata,
  output logic        av_write,
  input  logic        av_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        overflow,
`ifdef CAPTURE_CHECKSUM_EN
  output logic [31:0] frame_sum,
`endif
  output logic        line_err
);

  localparam int unsigned WordsPerLine = H_ACTIVE / 32;
  localparam int unsigned XW           = $clog2(H_ACTIVE + 1);
  localparam int unsigned YW           = $clog2(V_ACTIVE);
  localparam logic [14:0] Wpl          = 15'(WordsPerLine);

  typedef enum logic [1:0] {StIdle, StWaitVs, StCapture, StDone} state_e;

  state_e          state_q, state_d;
  logic            vga_clk_q;
  logic            vs_q, vs_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            in_line_q, in_line_d;
  logic [31:0]     shift_q, shift_d;
  logic            wr_q, wr_d;
  logic [14:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            lerr_q, lerr_d;
`ifdef CAPTURE_CHECKSUM_EN
  logic [31:0]     sum_q, sum_d;
`endif

  logic            strobe;
  logic            vs_rise;
  logic [9:0]      pix_sum;
  logic            pix_on;
  logic            accept;
  logic [14:0]     word_addr;
  logic [31:0]     shift_next;

  // hsync carries no information this block needs; it is deliberately left unused.
  logic unused_hs;
  assign unused_hs = VGA_HS;

  // One strobe per VGA_CLK rising edge; every VGA input is only looked at on it.
  assign strobe    = VGA_CLK & ~vga_clk_q;
  assign vs_rise   = strobe & VGA_VS & ~vs_q;
  assign pix_sum   = {2'b00, VGA_R} + {2'b00, VGA_G} + {2'b00, VGA_B};
  assign pix_on    = (pix_sum >= THRESH);
  assign accept    = wr_q & ~av_waitrequest;
  assign word_addr = 15'(y_q) * Wpl + 15'(x_q[XW-1:5]);

  always_comb begin
    state_d    = state_q;
    vs_d       = vs_q;
    x_d        = x_q;
    y_d        = y_q;
    in_line_d  = in_line_q;
    shift_d    = shift_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    lerr_d     = lerr_q;
`ifdef CAPTURE_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    shift_next = shift_q;
    shift_next[x_q[4:0]] = pix_on;

    if (strobe) begin
      vs_d = VGA_VS;
    end

    // The write port runs independently of the FSM so that abort or DONE never
    // truncates an in-flight write.
    if (accept) begin
      wr_d = 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
      sum_d = {sum_q[30:0], sum_q[31]} ^ data_q;
`endif
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StWaitVs;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          lerr_d  = 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      StWaitVs: begin
        if (vs_rise) begin
          state_d   = StCapture;
          x_d       = '0;
          y_d       = '0;
          in_line_d = 1'b0;
          shift_d   = '0;
        end
      end
      StCapture: begin
        if (strobe && VGA_BLANK_n) begin
          shift_d   = shift_next;
          x_d       = x_q + 1'b1;
          in_line_d = 1'b1;
          if (x_q[4:0] == 5'd31) begin
            // A pending write that is accepted this cycle frees the holding register.
            if (wr_q && av_waitrequest) begin
              ovf_d = 1'b1;
            end else begin
              wr_d   = 1'b1;
              addr_d = word_addr;
              data_d = shift_next;
            end
            shift_d = '0;
          end
        end else if (strobe && in_line_q) begin
          // First blank strobe after active video ends the line; a partial word is dropped.
          if (x_q != XW'(H_ACTIVE)) begin
            lerr_d = 1'b1;
          end
          x_d       = '0;
          y_d       = y_q + 1'b1;
          in_line_d = 1'b0;
          shift_d   = '0;
          if (y_q == YW'(V_ACTIVE - 1)) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      vga_clk_q <= 1'b0;
      vs_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      in_line_q <= 1'b0;
      shift_q   <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      lerr_q    <= 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      vga_clk_q <= VGA_CLK;
      vs_q      <= vs_d;
      x_q       <= x_d;
      y_q       <= y_d;
      in_line_q <= in_line_d;
      shift_q   <= shift_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      lerr_q    <= lerr_d;
`ifdef CAPTURE_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign av_address   = addr_q;
  assign av_writedata = data_q;
  assign av_write     = wr_q;
  assign busy         = (state_q == StWaitVs) || (state_q == StCapture);
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign line_err     = lerr_q;
`ifdef CAPTURE_CHECKSUM_EN
  assign frame_sum    = sum_q;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture, run on a reduced 128x8 frame to keep runtime short.
// Expected framebuffer writes come from an image array and the threshold rule.
module tb_vga_capture;

  localparam int H        = 128;
  localparam int V        = 8;
  localparam int HB       = 16;
  localparam int WPL      = H / 32;
  localparam int LINE_CLK = (H + HB) * 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic [14:0] av_address;
  logic [31:0] av_writedata;
  logic        av_write, av_waitrequest;
  logic        busy, done, overflow, line_err;
`ifdef CAPTURE_CHECKSUM_EN
  logic [31:0] frame_sum;
`endif

  vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .THRESH(10'd384)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .av_address(av_address), .av_writedata(av_writedata), .av_write(av_write),
    .av_waitrequest(av_waitrequest), .busy(busy), .done(done), .overflow(overflow),
`ifdef CAPTURE_CHECKSUM_EN
    .frame_sum(frame_sum),
`endif
    .line_err(line_err)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [14:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       exp_bit;
  } vec_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          stall_len = 0;
  logic        stall_once = 1'b0;
  wr_t         exp_q[$];
  wr_t         got_q[$];
  logic [23:0] img [V][H];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic lum(input logic [23:0] c);
    int s;
    s = int'(c[23:16]) + int'(c[15:8]) + int'(c[7:0]);
    return s >= 384;
  endfunction

  // Expected writes for one frame: every fully populated word, in raster order.
  function automatic void build_expected(input int sl, input int slen);
    int  len;
    wr_t e;
    exp_q.delete();
    for (int y = 0; y < V; y++) begin
      len = (y == sl) ? slen : H;
      for (int w = 0; w < WPL; w++) begin
        if ((w + 1) * 32 <= len) begin
          e.addr = 15'(y * WPL + w);
          e.data = '0;
          for (int b = 0; b < 32; b++) e.data[b] = lum(img[y][w*32+b]);
          exp_q.push_back(e);
        end
      end
    end
  endfunction

  // Slave model and write logger, evaluated away from the active edge.
  initial begin : slave
    int          hi_cnt;
    logic        was_stalled;
    logic [14:0] pa;
    logic [31:0] pd;
    hi_cnt = 0; was_stalled = 1'b0; pa = '0; pd = '0;
    av_waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hi_cnt = 0; was_stalled = 1'b0; av_waitrequest = 1'b0;
      end else begin
        if (was_stalled && av_write) begin
          check("stall_addr_stable", 64'(av_address), 64'(pa));
          check("stall_data_stable", 64'(av_writedata), 64'(pd));
        end
        hi_cnt = av_write ? hi_cnt + 1 : 0;
        av_waitrequest = av_write && (hi_cnt <= stall_len);
        was_stalled = av_write && av_waitrequest;
        pa = av_address;
        pd = av_writedata;
        if (av_write && !av_waitrequest) begin
          got_q.push_back('{addr: av_address, data: av_writedata});
          if (stall_once) stall_len = 0;
        end
      end
    end
  end

  task automatic pix(input logic bl, input logic hs, input logic vs, input logic [23:0] c);
    @(negedge clk);
    VGA_CLK = 1'b1; VGA_BLANK_n = bl; VGA_HS = hs; VGA_VS = vs;
    {VGA_R, VGA_G, VGA_B} = c;
    @(negedge clk);
    VGA_CLK = 1'b0;
  endtask

  task automatic blank_line(input logic vs);
    for (int i = 0; i < H + HB; i++) pix(1'b0, !(i >= 4 && i < 8), vs, 24'h0);
  endtask

  task automatic drive_frame(input int sl, input int slen);
    int len;
    blank_line(1'b0);
    blank_line(1'b0);
    blank_line(1'b1);
    for (int y = 0; y < V; y++) begin
      len = (y == sl) ? slen : H;
      for (int x = 0; x < len; x++) pix(1'b1, 1'b1, 1'b1, img[y][x]);
      for (int i = 0; i < HB; i++) pix(1'b0, !(i >= 4 && i < 8), 1'b1, 24'h0);
    end
    blank_line(1'b1);
  endtask

  task automatic fill(input int mode, input logic [23:0] c);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        img[y][x] = (mode == 0) ? c : {8'($urandom), 8'($urandom), 8'($urandom)};
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    if (which == 0) start = 1'b1; else abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
`ifdef CAPTURE_CHECKSUM_EN
    logic [31:0] s;
`endif
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_addr"}, 64'(got_q[i].addr), 64'(exp_q[i].addr));
      check({tag, "_data"}, 64'(got_q[i].data), 64'(exp_q[i].data));
    end
`ifdef CAPTURE_CHECKSUM_EN
    s = '0;
    foreach (exp_q[i]) s = {s[30:0], s[31]} ^ exp_q[i].data;
    check({tag, "_frame_sum"}, 64'(frame_sum), 64'(s));
`endif
  endtask

  task automatic run_frame(input int sl, input int slen);
    got_q.delete();
    build_expected(sl, slen);
    pulse(0);
    drive_frame(sl, slen);
    repeat (4) @(negedge clk);
  endtask

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin : main
    vec_t        vecs[14];
    logic [31:0] w0;
    int          nz, t;
    wr_t         hit;

    vecs[0]  = '{8'd128, 8'd128, 8'd128, 1'b1};
    vecs[1]  = '{8'd128, 8'd128, 8'd127, 1'b0};
    vecs[2]  = '{8'd255, 8'd255, 8'd255, 1'b1};
    vecs[3]  = '{8'd0,   8'd0,   8'd0,   1'b0};
    vecs[4]  = '{8'd255, 8'd129, 8'd0,   1'b1};
    vecs[5]  = '{8'd255, 8'd128, 8'd0,   1'b0};
    vecs[6]  = '{8'd200, 8'd100, 8'd83,  1'b0};
    vecs[7]  = '{8'd200, 8'd100, 8'd84,  1'b1};
    vecs[8]  = '{8'd255, 8'd255, 8'd0,   1'b1};
    vecs[9]  = '{8'd0,   8'd0,   8'd255, 1'b0};
    vecs[10] = '{8'd1,   8'd0,   8'd0,   1'b0};
    vecs[11] = '{8'd255, 8'd0,   8'd128, 1'b0};
    vecs[12] = '{8'd255, 8'd0,   8'd129, 1'b1};
    vecs[13] = '{8'd0,   8'd255, 8'd255, 1'b1};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    VGA_CLK = 1'b0; VGA_HS = 1'b1; VGA_VS = 1'b1; VGA_BLANK_n = 1'b0;
    VGA_R = '0; VGA_G = '0; VGA_B = '0;
    repeat (3) @(negedge clk);
    check("rst_av_write", 64'(av_write), 64'd0);
    check("rst_av_address", 64'(av_address), 64'd0);
    check("rst_av_writedata", 64'(av_writedata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_line_err", 64'(line_err), 64'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Threshold table on the first pixels of a random frame.
    fill(1, 24'h0);
    for (int i = 0; i < 14; i++) img[0][i] = {vecs[i].r, vecs[i].g, vecs[i].b};
    run_frame(-1, H);
    compare_writes("rand");
    w0 = (got_q.size() > 0) ? got_q[0].data : 32'hxxxxxxxx;
    for (int i = 0; i < 14; i++) check($sformatf("thresh_vec%0d", i), 64'(w0[i]), 64'(vecs[i].exp_bit));
    check("rand_done", 64'(done), 64'd1);
    check("rand_busy", 64'(busy), 64'd0);
    check("rand_overflow", 64'(overflow), 64'd0);
    check("rand_line_err", 64'(line_err), 64'd0);

    // All-white frame.
    fill(0, 24'hFFFFFF);
    run_frame(-1, H);
    compare_writes("white");
    check("white_last_addr", 64'(got_q.size() > 0 ? got_q[got_q.size()-1].addr : 15'h7fff),
          64'(V * WPL - 1));
    check("white_done", 64'(done), 64'd1);

    // Black frame with one white pixel at (33,1).
    fill(0, 24'h0);
    img[1][33] = 24'hFFFFFF;
    run_frame(-1, H);
    compare_writes("single");
    nz = 0; hit = '0;
    foreach (got_q[i]) if (got_q[i].data != 0) begin nz++; hit = got_q[i]; end
    check("single_nonzero_words", 64'(nz), 64'd1);
    check("single_addr", 64'(hit.addr), 64'(WPL + 1));
    check("single_data", 64'(hit.data), 64'h2);

    // Every write stalled for 10 clocks.
    fill(1, 24'h0);
    stall_len = 10; stall_once = 1'b0;
    run_frame(-1, H);
    stall_len = 0;
    compare_writes("stall10");
    check("stall10_overflow", 64'(overflow), 64'd0);

    // First write stalled 70 clocks: word 1 is dropped.
    fill(1, 24'h0);
    stall_len = 70; stall_once = 1'b1;
    got_q.delete();
    build_expected(-1, H);
    exp_q.delete(1);
    pulse(0);
    drive_frame(-1, H);
    repeat (4) @(negedge clk);
    stall_once = 1'b0; stall_len = 0;
    compare_writes("stall70");
    check("stall70_overflow", 64'(overflow), 64'd1);
    check("stall70_second_addr", 64'(got_q.size() > 1 ? got_q[1].addr : 15'h7fff), 64'd2);

    // Line 5 one pixel short.
    fill(1, 24'h0);
    got_q.delete();
    build_expected(5, H - 1);
    pulse(0);
    check("start_clears_overflow", 64'(overflow), 64'd0);
    drive_frame(5, H - 1);
    repeat (4) @(negedge clk);
    compare_writes("short");
    check("short_line_err", 64'(line_err), 64'd1);
    check("short_done", 64'(done), 64'd1);
    check("short_line6_addr", 64'(got_q.size() > 23 ? got_q[23].addr : 15'h7fff), 64'(6 * WPL));

    // Start mid-frame: nothing until the following VS rising edge.
    fill(1, 24'h0);
    got_q.delete();
    fork
      drive_frame(-1, H);
      begin
        repeat (4 * LINE_CLK) @(negedge clk);
        pulse(0);
      end
    join
    check("midframe_no_writes", 64'(got_q.size()), 64'd0);
    check("midframe_busy", 64'(busy), 64'd1);
    fill(1, 24'h0);
    build_expected(-1, H);
    drive_frame(-1, H);
    repeat (4) @(negedge clk);
    compare_writes("midframe_next");

    // Reset during a stalled write, with overflow already set.
    fill(0, 24'hFFFFFF);
    stall_len = 1000; stall_once = 1'b0;
    pulse(0);
    fork
      drive_frame(-1, H);
      begin
        t = 0;
        while (!overflow && t < 8000) begin @(negedge clk); t++; end
        check("pre_reset_overflow", 64'(overflow), 64'd1);
        check("pre_reset_av_write", 64'(av_write), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_reset_av_write", 64'(av_write), 64'd0);
        check("mid_reset_busy", 64'(busy), 64'd0);
        check("mid_reset_done", 64'(done), 64'd0);
        check("mid_reset_overflow", 64'(overflow), 64'd0);
        check("mid_reset_line_err", 64'(line_err), 64'd0);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
      end
    join
    stall_len = 0;

    // Abort returns to idle.
    pulse(0);
    check("abort_pre_busy", 64'(busy), 64'd1);
    pulse(1);
    check("abort_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
